fetch_unit: RTL and testbench

- Program-counter and fetch sequencer. It is the consumer end of the control decoder's branch-enable interface.
- Takes BeqEn/BtrEn from the decoder, the ALU flags and a halt request.
- Drives the instruction ROM address (ProgCtr) each cycle and sequences start/run/halt of a program.
- Keeps cycle and taken-branch counters for the lab's performance reporting.

---
 rtl/fetch_unit_if.sv | 30 +++
 rtl/fetch_unit.sv | 83 ++++++++
 tb/tb_fetch_unit.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/fetch_unit_if.sv
// Decoder/ALU-to-fetch interface: branch enables, flags, halt request and
// the fetch unit's PC, status and performance-counter outputs.
interface fetch_if #(
  parameter int PC_W  = 10,
  parameter int CNT_W = 16
);
  logic             Start;
  logic             Stall;
  logic             HaltReq;
  logic             BeqEn;
  logic             BtrEn;
  logic             ZeroFlag;
  logic             CondFlag;
  logic [PC_W-1:0]  Target;
  logic [PC_W-1:0]  ProgCtr;
  logic             InstrValid;
  logic             Done;
  logic [CNT_W-1:0] CycleCount;
  logic [CNT_W-1:0] BranchCount;

  modport master (
    output Start, Stall, HaltReq, BeqEn, BtrEn, ZeroFlag, CondFlag, Target,
    input  ProgCtr, InstrValid, Done, CycleCount, BranchCount
  );

  modport slave (
    input  Start, Stall, HaltReq, BeqEn, BtrEn, ZeroFlag, CondFlag, Target,
    output ProgCtr, InstrValid, Done, CycleCount, BranchCount
  );
endinterface

// File: rtl/fetch_unit.sv
// Program counter and fetch sequencer: IDLE/RUN/HALTED control, branch
// resolution from decoder enables and ALU flags, saturating perf counters.
module fetch_unit #(
  parameter int PC_W       = 10,
  parameter int START_ADDR = 0,
  parameter int CNT_W      = 16
) (
  input  logic   Clk,
  input  logic   Reset,
  fetch_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [PC_W-1:0]  pc_q, pc_d;
  logic [CNT_W-1:0] cyc_q, cyc_d;
  logic [CNT_W-1:0] br_q, br_d;
  logic             taken;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign taken = (bus.BeqEn & bus.ZeroFlag) | (bus.BtrEn & bus.CondFlag);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cyc_d   = cyc_q;
    br_d    = br_q;
    unique case (state_q)
      IDLE, HALTED: begin
        if (bus.Start) begin
          state_d = RUN;
          pc_d    = PC_W'(START_ADDR);
          cyc_d   = '0;
          br_d    = '0;
        end
      end
      RUN: begin
        // Stalled cycles still count as RUN time; Start is ignored here.
        cyc_d = sat_inc(cyc_q);
        if (!bus.Stall) begin
          if (bus.HaltReq) begin
            state_d = HALTED;
          end else if (taken) begin
            pc_d = bus.Target;
            br_d = sat_inc(br_q);
          end else begin
            pc_d = pc_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= IDLE;
      pc_q    <= '0;
      cyc_q   <= '0;
      br_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cyc_q   <= cyc_d;
      br_q    <= br_d;
    end
  end

  assign bus.ProgCtr     = pc_q;
  assign bus.InstrValid  = (state_q == RUN);
  assign bus.Done        = (state_q == HALTED);
  assign bus.CycleCount  = cyc_q;
  assign bus.BranchCount = br_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a cycle-level reference model checked
// every cycle, plus literal expectations at key points of each scenario.
module tb_fetch_unit;
  localparam int PC_W       = 10;
  localparam int START_ADDR = 0;
  localparam int CNT_W      = 16;
  localparam int CMAX       = (1 << CNT_W) - 1;

  logic Clk;
  logic Reset;
  bit   check_en;
  int   n_cmp;
  int   n_bad;

  // Reference model state: 0 = idle, 1 = running, 2 = halted.
  int m_state, m_pc, m_cyc, m_br;

  fetch_if #(.PC_W(PC_W), .CNT_W(CNT_W)) bus ();

  fetch_unit #(
    .PC_W(PC_W), .START_ADDR(START_ADDR), .CNT_W(CNT_W)
  ) dut (
    .Clk  (Clk),
    .Reset(Reset),
    .bus  (bus.slave)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  function automatic int imin(int a, int b);
    return (a < b) ? a : b;
  endfunction

  always @(posedge Clk) begin
    if (Reset) begin
      m_state = 0; m_pc = 0; m_cyc = 0; m_br = 0;
    end else if (m_state != 1) begin
      if (bus.Start) begin
        m_state = 1; m_pc = START_ADDR; m_cyc = 0; m_br = 0;
      end
    end else begin
      m_cyc = imin(m_cyc + 1, CMAX);
      if (!bus.Stall) begin
        if (bus.HaltReq)
          m_state = 2;
        else if ((bus.BeqEn && bus.ZeroFlag) || (bus.BtrEn && bus.CondFlag)) begin
          m_pc = int'(bus.Target);
          m_br = imin(m_br + 1, CMAX);
        end else
          m_pc = (m_pc + 1) % (1 << PC_W);
      end
    end
  end

  always @(negedge Clk) begin
    if (check_en) begin
      n_cmp += 5;
      if (int'(bus.ProgCtr) !== m_pc) begin
        n_bad++; $display("FAIL model_pc: got %0h expected %0h at %0t", bus.ProgCtr, m_pc, $time);
      end
      if (bus.InstrValid !== (m_state == 1)) begin
        n_bad++; $display("FAIL model_ivalid: got %0b expected %0b at %0t", bus.InstrValid, m_state == 1, $time);
      end
      if (bus.Done !== (m_state == 2)) begin
        n_bad++; $display("FAIL model_done: got %0b expected %0b at %0t", bus.Done, m_state == 2, $time);
      end
      if (int'(bus.CycleCount) !== m_cyc) begin
        n_bad++; $display("FAIL model_cyc: got %0d expected %0d at %0t", bus.CycleCount, m_cyc, $time);
      end
      if (int'(bus.BranchCount) !== m_br) begin
        n_bad++; $display("FAIL model_br: got %0d expected %0d at %0t", bus.BranchCount, m_br, $time);
      end
    end
  end

  task automatic lit(input string nm, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic lit_all(input string nm, input int pc, input int iv, input int dn,
                         input int cyc, input int br);
    lit({nm, "_pc"},  int'(bus.ProgCtr),     pc);
    lit({nm, "_iv"},  int'(bus.InstrValid),  iv);
    lit({nm, "_done"},int'(bus.Done),        dn);
    lit({nm, "_cyc"}, int'(bus.CycleCount),  cyc);
    lit({nm, "_br"},  int'(bus.BranchCount), br);
  endtask

  // Advance one clock; return 1ns after the falling edge for literal checks.
  task automatic tick();
    @(negedge Clk);
    #1;
  endtask

  task automatic clr_inputs();
    bus.Start = 0; bus.Stall = 0; bus.HaltReq = 0; bus.BeqEn = 0;
    bus.BtrEn = 0; bus.ZeroFlag = 0; bus.CondFlag = 0; bus.Target = '0;
  endtask

  initial begin
    n_cmp = 0; n_bad = 0; check_en = 0;
    Reset = 1;
    clr_inputs();
    tick();
    check_en = 1;
    tick();
    Reset = 0;
    lit_all("reset", 0, 0, 0, 0, 0);

    // Start, then five plain increments
    bus.Start = 1; tick(); bus.Start = 0;
    lit_all("start", 0, 1, 0, 0, 0);
    repeat (5) tick();
    lit_all("run5", 5, 1, 0, 5, 0);

    // Start during RUN is ignored
    bus.Start = 1; tick(); bus.Start = 0;
    lit_all("start_in_run", 6, 1, 0, 6, 0);

    // Branch to 0x22, then reset mid-run
    bus.BeqEn = 1; bus.ZeroFlag = 1; bus.Target = 10'h22; tick(); clr_inputs();
    lit_all("br22", 'h22, 1, 0, 7, 1);
    Reset = 1; tick(); Reset = 0;
    lit_all("mid_reset", 0, 0, 0, 0, 0);

    // Beq taken at PC=3, then not-taken at PC=3
    bus.Start = 1; tick(); bus.Start = 0;
    repeat (3) tick();
    lit("pc3", int'(bus.ProgCtr), 3);
    bus.BeqEn = 1; bus.ZeroFlag = 1; bus.Target = 10'h40; tick();
    lit_all("beq_taken", 'h40, 1, 0, 4, 1);
    bus.Target = 10'h3; tick();
    bus.ZeroFlag = 0; tick(); clr_inputs();
    lit_all("beq_not", 4, 1, 0, 6, 2);

    // Stall at PC=5 with a pending taken branch
    tick();
    bus.Stall = 1; bus.BeqEn = 1; bus.ZeroFlag = 1; bus.Target = 10'h100;
    repeat (3) tick();
    lit_all("stall3", 5, 1, 0, 10, 2);
    bus.HaltReq = 1; tick(); bus.HaltReq = 0;
    lit_all("stall_halt", 5, 1, 0, 11, 2);
    bus.Stall = 0; tick(); clr_inputs();
    lit_all("unstall_br", 'h100, 1, 0, 12, 3);

    // Both enables set, only CondFlag qualifies
    bus.BeqEn = 1; bus.BtrEn = 1; bus.CondFlag = 1; bus.Target = 10'h3FF; tick(); clr_inputs();
    lit_all("dual_en", 'h3FF, 1, 0, 13, 4);
    tick();
    lit_all("wrap", 0, 1, 0, 14, 4);

    // Halt at PC=7 beats a taken Btr
    repeat (7) tick();
    bus.BtrEn = 1; bus.CondFlag = 1; bus.HaltReq = 1; bus.Target = 10'h10; tick();
    lit_all("halt", 7, 0, 1, 22, 4);
    repeat (2) tick();
    clr_inputs();
    lit_all("halt_hold", 7, 0, 1, 22, 4);
    bus.Start = 1; tick(); bus.Start = 0;
    lit_all("restart", 0, 1, 0, 0, 0);

    // Saturation: branch every cycle past the counter limit
    bus.BeqEn = 1; bus.ZeroFlag = 1; bus.Target = 10'h55;
    repeat (CMAX + 5) @(negedge Clk);
    #1;
    lit_all("saturate", 'h55, 1, 0, CMAX, CMAX);
    clr_inputs();
    tick();
    lit_all("sat_hold", 'h56, 1, 0, CMAX, CMAX);

    check_en = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
